// File: rtl/cpu_types_pkg.sv
`default_nettype none
// cpu_types_pkg: shared data-cache types (word, address split, controller state). Rev 1.0
package cpu_types_pkg;

  localparam int DC_TAG_W = 26;
  localparam int DC_IDX_W = 3;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [DC_TAG_W-1:0] tag;
    logic [DC_IDX_W-1:0] idx;
    logic                blkoff;
    logic [1:0]          bytoff;
  } dcaddr_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB0    = 3'd1,
    WB1    = 3'd2,
    FETCH0 = 3'd3,
    FETCH1 = 3'd4
  } dcache_state_t;

  function automatic logic [DC_TAG_W-1:0] addr_tag(input word_t a);
    dcaddr_t s;
    s = a;
    return s.tag;
  endfunction

  function automatic logic [DC_IDX_W-1:0] addr_idx(input word_t a);
    dcaddr_t s;
    s = a;
    return s.idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_lru.sv
`default_nettype none
// dcache_lru: per-set most-recently-used way bits and replacement-way selection. Rev 1.0
module dcache_lru #(
  parameter int NSETS = 8,
  parameter int IDX_W = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic             valid0_i,
  input  logic             valid1_i,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_way_i,
  output logic             victim_o
);

  logic [NSETS-1:0] lru_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lru_q <= '0;
    end else if (upd_en_i) begin
      lru_q[upd_idx_i] <= upd_way_i;
    end
  end

  // An invalid way is always preferred; way 0 wins when both are empty.
  always_comb begin
    victim_o = 1'b0;
    if (valid0_i && valid1_i) begin
      victim_o = ~lru_q[rd_idx_i];
    end else if (valid0_i) begin
      victim_o = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// dcache_controller: 2-way D$ miss handling (writeback + 2-word refill) and LRU owner.
// Optional hit counter enabled by DCACHE_HITCNT_EN. Rev 1.0
module dcache_controller
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic        miss,
  input  logic        setsel,
  input  logic        valid0,
  input  logic        valid1,
  input  logic        dirty0,
  input  logic        dirty1,
  input  logic [25:0] tag0,
  input  logic [25:0] tag1,
  input  logic [63:0] data0,
  input  logic [63:0] data1,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic        fill_en,
  output logic        fill_way,
  output logic        fill_word,
  output logic [31:0] fill_data,
  output logic        tag_wen,
  output logic        victim,
  output logic        dhit
`ifdef DCACHE_HITCNT_EN
  ,
  output logic [31:0] hit_count
`endif
);

  dcache_state_t         state_q;
  logic [DC_IDX_W-1:0]   idx_q;
  logic [DC_TAG_W-1:0]   tag_q;
  logic                  victim_q;
  logic [DC_TAG_W-1:0]   vtag_q;
  logic [63:0]           vdata_q;

  logic [DC_IDX_W-1:0]   req_idx;
  logic [DC_TAG_W-1:0]   req_tag;
  logic                  req;
  logic                  vic_valid;
  logic                  vic_dirty;
  logic                  lru_upd_en;
  logic [DC_IDX_W-1:0]   lru_upd_idx;
  logic                  lru_upd_way;

  assign req_idx   = addr_idx(dmemaddr);
  assign req_tag   = addr_tag(dmemaddr);
  assign req       = dmemREN | dmemWEN;
  assign vic_valid = victim ? valid1 : valid0;
  assign vic_dirty = victim ? dirty1 : dirty0;
  assign dhit      = (state_q == IDLE) && req && !miss;
  assign fill_data = dload;

  dcache_lru #(
    .NSETS (NSETS),
    .IDX_W (DC_IDX_W)
  ) u_lru (
    .CLK       (CLK),
    .nRST      (nRST),
    .rd_idx_i  (req_idx),
    .valid0_i  (valid0),
    .valid1_i  (valid1),
    .upd_en_i  (lru_upd_en),
    .upd_idx_i (lru_upd_idx),
    .upd_way_i (lru_upd_way),
    .victim_o  (victim)
  );

  // Victim tag and words are captured at the miss so a moving request address cannot corrupt the writeback.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      victim_q <= 1'b0;
      vtag_q   <= '0;
      vdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && miss) begin
            idx_q    <= req_idx;
            tag_q    <= req_tag;
            victim_q <= victim;
            vtag_q   <= victim ? tag1 : tag0;
            vdata_q  <= victim ? data1 : data0;
            state_q  <= (vic_valid && vic_dirty) ? WB0 : FETCH0;
          end
        end
        WB0:     if (!dwait) state_q <= WB1;
        WB1:     if (!dwait) state_q <= FETCH0;
        FETCH0:  if (!dwait) state_q <= FETCH1;
        FETCH1:  if (!dwait) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    fill_en     = 1'b0;
    fill_way    = 1'b0;
    fill_word   = 1'b0;
    tag_wen     = 1'b0;
    lru_upd_en  = 1'b0;
    lru_upd_idx = req_idx;
    lru_upd_way = setsel;
    case (state_q)
      IDLE: begin
        lru_upd_en = dhit;
      end
      WB0: begin
        dWEN   = 1'b1;
        daddr  = {vtag_q, idx_q, 1'b0, 2'b00};
        dstore = vdata_q[31:0];
      end
      WB1: begin
        dWEN   = 1'b1;
        daddr  = {vtag_q, idx_q, 1'b1, 2'b00};
        dstore = vdata_q[63:32];
      end
      FETCH0: begin
        dREN     = 1'b1;
        daddr    = {tag_q, idx_q, 1'b0, 2'b00};
        fill_way = victim_q;
        fill_en  = !dwait;
      end
      FETCH1: begin
        dREN        = 1'b1;
        daddr       = {tag_q, idx_q, 1'b1, 2'b00};
        fill_way    = victim_q;
        fill_word   = 1'b1;
        fill_en     = !dwait;
        tag_wen     = !dwait;
        lru_upd_en  = !dwait;
        lru_upd_idx = idx_q;
        lru_upd_way = victim_q;
      end
      default: begin
        dREN = 1'b0;
      end
    endcase
  end

`ifdef DCACHE_HITCNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] hit_cnt_d;

  assign hit_cnt_d = hit_cnt_q + 32'd1;
  assign hit_count = hit_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q <= '0;
    end else if (dhit) begin
      hit_cnt_q <= hit_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// tb_dcache_controller: directed self-checking bench for the D$ miss controller. Rev 1.0
module tb_dcache_controller;

  logic        CLK, nRST;
  logic        dmemREN, dmemWEN, miss, setsel;
  logic        valid0, valid1, dirty0, dirty1, dwait;
  logic [31:0] dmemaddr, dload;
  logic [25:0] tag0, tag1;
  logic [63:0] data0, data1;
  logic        dREN, dWEN, fill_en, fill_way, fill_word, tag_wen, victim, dhit;
  logic [31:0] daddr, dstore, fill_data;
`ifdef DCACHE_HITCNT_EN
  logic [31:0] hit_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  dcache_controller #(.NSETS(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .dmemREN   (dmemREN),
    .dmemWEN   (dmemWEN),
    .dmemaddr  (dmemaddr),
    .miss      (miss),
    .setsel    (setsel),
    .valid0    (valid0),
    .valid1    (valid1),
    .dirty0    (dirty0),
    .dirty1    (dirty1),
    .tag0      (tag0),
    .tag1      (tag1),
    .data0     (data0),
    .data1     (data1),
    .dwait     (dwait),
    .dload     (dload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .fill_en   (fill_en),
    .fill_way  (fill_way),
    .fill_word (fill_word),
    .fill_data (fill_data),
    .tag_wen   (tag_wen),
    .victim    (victim),
    .dhit      (dhit)
`ifdef DCACHE_HITCNT_EN
    ,
    .hit_count (hit_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    nRST = 1'b0; dmemREN = 0; dmemWEN = 0; dmemaddr = '0; miss = 0; setsel = 0;
    valid0 = 0; valid1 = 0; dirty0 = 0; dirty1 = 0; tag0 = '0; tag1 = '0;
    data0 = '0; data1 = '0; dwait = 0; dload = '0;

    // Reset state
    step();
    chk("rst_dREN", {31'd0, dREN}, 32'd0);
    chk("rst_dWEN", {31'd0, dWEN}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    chk("rst_fill_en", {31'd0, fill_en}, 32'd0);
    chk("rst_tag_wen", {31'd0, tag_wen}, 32'd0);
    chk("rst_victim", {31'd0, victim}, 32'd0);
    chk("rst_dhit", {31'd0, dhit}, 32'd0);
`ifdef DCACHE_HITCNT_EN
    chk("rst_hit_count", hit_count, 32'd0);
`endif
    nRST = 1'b1;

    // Cold read miss at 0x40, zero wait
    dmemREN = 1; dmemaddr = 32'h40; miss = 1; dload = 32'hAAAA_0000;
    #1;
    chk("cold_dhit0", {31'd0, dhit}, 32'd0);
    chk("cold_victim", {31'd0, victim}, 32'd0);
    chk("cold_idle_dREN", {31'd0, dREN}, 32'd0);
    step();
    chk("cold_f0_dREN", {31'd0, dREN}, 32'd1);
    chk("cold_f0_dWEN", {31'd0, dWEN}, 32'd0);
    chk("cold_f0_daddr", daddr, 32'h40);
    chk("cold_f0_fill_en", {31'd0, fill_en}, 32'd1);
    chk("cold_f0_fill_word", {31'd0, fill_word}, 32'd0);
    chk("cold_f0_fill_way", {31'd0, fill_way}, 32'd0);
    chk("cold_f0_fill_data", fill_data, 32'hAAAA_0000);
    chk("cold_f0_tag_wen", {31'd0, tag_wen}, 32'd0);
    dload = 32'hBBBB_1111;
    step();
    chk("cold_f1_daddr", daddr, 32'h44);
    chk("cold_f1_fill_en", {31'd0, fill_en}, 32'd1);
    chk("cold_f1_fill_word", {31'd0, fill_word}, 32'd1);
    chk("cold_f1_tag_wen", {31'd0, tag_wen}, 32'd1);
    chk("cold_f1_fill_data", fill_data, 32'hBBBB_1111);
    step();
    miss = 0; setsel = 0; valid0 = 1; tag0 = 26'h1;
    #1;
    chk("cold_retry_dhit", {31'd0, dhit}, 32'd1);
    chk("cold_retry_dREN", {31'd0, dREN}, 32'd0);
    chk("cold_retry_tag_wen", {31'd0, tag_wen}, 32'd0);

    // Hit on way 1, index 2 (tag 5)
    step();
    dmemaddr = 32'h150; valid0 = 1; valid1 = 1; miss = 0; setsel = 1;
    #1;
    chk("hit2_dhit", {31'd0, dhit}, 32'd1);
    chk("hit2_victim_before", {31'd0, victim}, 32'd1);
    step();
    dmemREN = 0;
    #1;
    chk("hit2_victim_after", {31'd0, victim}, 32'd0);
    chk("hit2_dhit_idle", {31'd0, dhit}, 32'd0);

    // Write miss at index 1 with dirty victim in way 1 (tag 3)
    dmemWEN = 1; dmemaddr = 32'h248; miss = 1; tag0 = 26'h7; tag1 = 26'h3;
    dirty0 = 0; dirty1 = 1; data0 = {32'h5555_5555, 32'h6666_6666};
    data1 = {32'h1111_1111, 32'h2222_2222};
    #1;
    chk("dirty_victim", {31'd0, victim}, 32'd1);
    chk("dirty_dhit0", {31'd0, dhit}, 32'd0);
    step();
    dmemaddr = 32'h0; tag1 = 26'h0; data1 = '0;
    #1;
    chk("wb0_dWEN", {31'd0, dWEN}, 32'd1);
    chk("wb0_dREN", {31'd0, dREN}, 32'd0);
    chk("wb0_daddr", daddr, 32'hC8);
    chk("wb0_dstore", dstore, 32'h2222_2222);
    step();
    chk("wb1_dWEN", {31'd0, dWEN}, 32'd1);
    chk("wb1_daddr", daddr, 32'hCC);
    chk("wb1_dstore", dstore, 32'h1111_1111);
    step();
    dwait = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_dREN", {31'd0, dREN}, 32'd1);
      chk("stall_dWEN", {31'd0, dWEN}, 32'd0);
      chk("stall_daddr", daddr, 32'h248);
      chk("stall_fill_en", {31'd0, fill_en}, 32'd0);
      step();
    end
    dwait = 0;
    #1;
    chk("release_fill_en", {31'd0, fill_en}, 32'd1);
    chk("release_fill_word", {31'd0, fill_word}, 32'd0);
    chk("release_fill_way", {31'd0, fill_way}, 32'd1);
    chk("release_daddr", daddr, 32'h248);
    step();
    chk("dirty_f1_daddr", daddr, 32'h24C);
    chk("dirty_f1_tag_wen", {31'd0, tag_wen}, 32'd1);
    chk("dirty_f1_fill_way", {31'd0, fill_way}, 32'd1);
    step();
    dmemaddr = 32'h248; tag1 = 26'h9; dirty1 = 0; miss = 0; setsel = 1;
    #1;
    chk("dirty_retry_dhit", {31'd0, dhit}, 32'd1);
    chk("dirty_retry_dWEN", {31'd0, dWEN}, 32'd0);

    // Reset asserted mid-refill
    step();
    dmemWEN = 0; dmemREN = 1; dmemaddr = 32'h98; miss = 1;
    #1;
    chk("rstmid_victim", {31'd0, victim}, 32'd1);
    step();
    chk("rstmid_f0_daddr", daddr, 32'h98);
    step();
    dwait = 1;
    #1;
    chk("rstmid_f1_daddr", daddr, 32'h9C);
    chk("rstmid_f1_tag_wen", {31'd0, tag_wen}, 32'd0);
    nRST = 0;
    #1;
    chk("rstmid_dREN", {31'd0, dREN}, 32'd0);
    chk("rstmid_dWEN", {31'd0, dWEN}, 32'd0);
    chk("rstmid_daddr", daddr, 32'd0);
    chk("rstmid_fill_en", {31'd0, fill_en}, 32'd0);
    chk("rstmid_tag_wen", {31'd0, tag_wen}, 32'd0);
    chk("rstmid_fill_way", {31'd0, fill_way}, 32'd0);
    dwait = 0;
    step();
    chk("rstmid_hold_tag_wen", {31'd0, tag_wen}, 32'd0);
    dmemREN = 0; miss = 0; nRST = 1;
    step();
    dmemaddr = 32'h150;
    #1;
    chk("rstmid_idle_dREN", {31'd0, dREN}, 32'd0);
    chk("rstmid_lru_cleared", {31'd0, victim}, 32'd1);

    // Five hits, then a clean miss followed by its hit
    dmemREN = 1; setsel = 0; miss = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cnt_hit_dhit", {31'd0, dhit}, 32'd1);
      step();
    end
    dmemaddr = 32'h98; miss = 1;
    #1;
    chk("cnt_miss_dhit", {31'd0, dhit}, 32'd0);
    step();
    step();
    step();
    miss = 0;
    #1;
    chk("cnt_retry_dhit", {31'd0, dhit}, 32'd1);
    step();
    dmemREN = 0;
    #1;
`ifdef DCACHE_HITCNT_EN
    chk("hit_count", hit_count, 32'd6);
`endif
    chk("final_dREN", {31'd0, dREN}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Miss-handling and replacement controller for the 2-way set-associative data cache. Sits between the combinational hit/miss access logic and the memory-side bus, and sequences dirty-victim writeback and two-word block refill. Also owns the per-set LRU state and drives the tag/data array write strobes. The pipeline stalls on the access logic's `miss` until this block reports `dhit`.

## Interface
- `NSETS`, 8: number of sets (index width log2).
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `dmemREN`, `dmemWEN`  in  1  datapath read/write request (mutually exclusive).
- `dmemaddr`  in  32  request address: tag[31:6], index[5:3], offset[2], byte[1:0].
- `miss`, `setsel`  in  1  from access logic; `setsel` is the hit way.
- `valid0`, `valid1`, `dirty0`, `dirty1`  in  1  metadata of the indexed set.
- `tag0`, `tag1`  in  26  tags of the indexed set.
- `data0`, `data1`  in  2x32  block words of the indexed set.
- `dwait`  in  1  memory busy; transfer completes in the cycle it is low.
- `dload`  in  32  memory read data.
- `dREN`, `dWEN`  out  1  memory read/write strobe.
- `daddr`, `dstore`  out  32  memory address / write data.
- `fill_en`, `fill_way`, `fill_word`  out  1  data-array refill strobe, way, word offset.
- `fill_data`  out  32  refill word (= `dload`).
- `tag_wen`  out  1  write `tag[31:6]` into `fill_way`; set valid, clear dirty.
- `victim`  out  1  replacement way for the current index.
- `dhit`  out  1  request serviced this cycle.
- `hit_count`  out  32  only with `DCACHE_HITCNT_EN`.

## Operation
- States: IDLE, WB0, WB1, FETCH0, FETCH1.
- LRU: `lru[NSETS]`, bit = most-recently-used way. `victim` = invalid way if exactly one invalid (way 0 if both invalid), else `~lru[index]`.
- IDLE: request && !miss → `dhit`=1, `lru[index]<=setsel`. Request && miss → latch index, tag, victim. Go WB0 if victim valid && dirty, else FETCH0.
- WB0/WB1: `dWEN`=1, `daddr`={victim tag, index, word, 2'b00}, `dstore`=victim data word 0/1. Advance on `dwait`=0; WB1 → FETCH0.
- FETCH0/FETCH1: `dREN`=1, `daddr`={latched tag, index, word, 2'b00}. On `dwait`=0: `fill_en`=1, `fill_word`=0/1, `fill_way`=latched victim. FETCH1 also asserts `tag_wen`, sets `lru[index]<=victim`, then returns to IDLE.
- Retry: after refill, IDLE re-evaluates the now-hitting access; a write sets dirty via the access-logic path, not here.
- `dREN` and `dWEN` are never high together. No memory strobe is asserted in IDLE.
- Request deasserted mid-miss: the sequence completes anyway; the line is installed.
- Address change mid-miss: ignored; latched index/tag/victim are used.

## Timing
- Reset: state IDLE, `lru` all 0, every output 0 (`hit_count` 0).
- Hit: `dhit` is combinational, in the same cycle as the request.
- Miss, clean victim, zero wait: FETCH0 at +1, FETCH1 at +2, IDLE at +3, `dhit` at +3. Dirty victim adds 2 cycles. Each `dwait`-high cycle adds 1.
- Registered: state, LRU, and latches. Memory outputs decode combinationally from state and latches.
- `nRST` low at any point returns to IDLE immediately and drops all strobes. A partial refill leaves the line invalid, because `tag_wen` was never issued.

## Configuration
- `DCACHE_HITCNT_EN` defined: 32-bit `hit_count` increments on every `dhit`, wraps 0xFFFFFFFF → 0, cleared only by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- `cpu_types_pkg`: `word_t`, the dcache address split struct (tag/idx/blkoff/bytoff), and `dcache_state_t` enum.
- Sub-module `dcache_lru`: LRU bit array with read port on index, update port (en, index, way), and victim selection.

## Test plan
- Reset then read 0x0000_0040, cold miss, `dwait`=0 → `dREN` with `daddr` 0x40 then 0x44; `fill_en` twice, way 0; `tag_wen`; `dhit` at cycle 3.
- Hit way 1 at index 2 → `dhit` same cycle; `lru[2]`=1; `victim`=0.
- Miss with dirty victim tag 0x3, index 1 → `dWEN` to 0xC8 then 0xCC with the victim words; then `dREN` to the new block.
- `dwait` held high 4 cycles in FETCH0 → `daddr` and `dREN` stable; `fill_en` only on the release cycle.
- `nRST` asserted during FETCH1 → all outputs 0 next edge-independent; `tag_wen` never seen; state IDLE.
- With `DCACHE_HITCNT_EN`: 5 hits and 1 miss-then-hit → `hit_count`=6.
